// File: rtl/fir_filter_mac_sched.sv
// rtl/fir_filter_mac_sched.sv - shared-multiplier MAC scheduler for an N-tap FIR filter
//
// Purpose: accepts one sample per handshake into an N-tap delay line, walks every
// tap through one external signed multiplier (one product per cycle), accumulates
// and presents the filtered result on an output handshake. Holds the coefficients.
//
// Ports:
//   ap_clk, ap_rst_n             clock, asynchronous active-low reset
//   s_data/s_valid/s_ready       input sample stream (s_ready high only in IDLE)
//   coef_we/coef_addr/coef_data  coefficient write port (honoured only in IDLE)
//   coef_err                     one-cycle pulse per dropped coefficient write
//   mul_a/mul_b/mul_p            external multiplier operands and product
//   m_data/m_valid/m_ready       filtered result stream
//   busy                         high while in MAC or OUT
module fir_filter_mac_sched #(
  parameter int N_TAPS = 16,
  parameter int DATA_W = 18,
  parameter int ACC_W  = 40
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  input  logic signed [DATA_W-1:0]    s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic                        coef_we,
  input  logic [$clog2(N_TAPS)-1:0]   coef_addr,
  input  logic signed [DATA_W-1:0]    coef_data,
  output logic                        coef_err,
  output logic signed [DATA_W-1:0]    mul_a,
  output logic signed [DATA_W-1:0]    mul_b,
  input  logic signed [2*DATA_W-1:0]  mul_p,
  output logic signed [ACC_W-1:0]     m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic                        busy
);

  localparam int AW = $clog2(N_TAPS);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic signed [DATA_W-1:0]  r_x    [N_TAPS];
  logic signed [DATA_W-1:0]  r_coef [N_TAPS];
  logic [AW-1:0]             r_idx;
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [ACC_W-1:0]   r_m_data;
  logic                      r_m_valid;
  logic                      r_coef_err;

  logic                      w_last;
  logic                      w_addr_ok;
  logic                      w_coef_wr;
  logic signed [ACC_W-1:0]   w_prod_ext;
  logic signed [ACC_W-1:0]   w_sum;

  assign w_last     = (r_idx == AW'(N_TAPS - 1));
  // Widened by one bit so that N_TAPS itself is representable in the compare.
  assign w_addr_ok  = ({1'b0, coef_addr} < (AW + 1)'(N_TAPS));
  assign w_coef_wr  = coef_we && (r_state == S_IDLE) && w_addr_ok;
  assign w_prod_ext = {{(ACC_W - 2*DATA_W){mul_p[2*DATA_W-1]}}, mul_p};
  assign w_sum      = r_acc + w_prod_ext;

  assign m_data   = r_m_data;
  assign m_valid  = r_m_valid;
  assign coef_err = r_coef_err;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    s_ready = 1'b0;
    busy    = 1'b0;
    mul_a   = '0;
    mul_b   = '0;
    case (r_state)
      S_IDLE: begin
        s_ready = 1'b1;
        if (s_valid) w_next = S_MAC;
      end
      S_MAC: begin
        busy  = 1'b1;
        mul_a = r_x[r_idx];
        mul_b = r_coef[r_idx];
        if (w_last) w_next = S_OUT;
      end
      S_OUT: begin
        busy = 1'b1;
        if (m_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int k = 0; k < N_TAPS; k++) begin
        r_x[k]    <= '0;
        r_coef[k] <= '0;
      end
      r_idx      <= '0;
      r_acc      <= '0;
      r_m_data   <= '0;
      r_m_valid  <= 1'b0;
      r_coef_err <= 1'b0;
    end else begin
      r_coef_err <= coef_we && !w_coef_wr;
      // A write coinciding with sample acceptance lands before the first MAC cycle.
      if (w_coef_wr) r_coef[coef_addr] <= coef_data;
      case (r_state)
        S_IDLE: begin
          if (s_valid) begin
            for (int k = N_TAPS - 1; k > 0; k--) r_x[k] <= r_x[k-1];
            r_x[0] <= s_data;
            r_acc  <= '0;
            r_idx  <= '0;
          end
        end
        S_MAC: begin
          r_acc <= w_sum;
          r_idx <= r_idx + AW'(1);
          if (w_last) begin
            r_m_data  <= w_sum;
            r_m_valid <= 1'b1;
          end
        end
        S_OUT: begin
          if (m_ready) r_m_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_filter_mac_sched.sv
// tb/tb_fir_filter_mac_sched.sv - self-checking bench for fir_filter_mac_sched
module tb_fir_filter_mac_sched;

  logic               ap_clk = 1'b0;
  logic               ap_rst_n = 1'b0;
  logic signed [17:0] s_data = '0;
  logic               s_valid = 1'b0;
  logic               s_ready;
  logic               coef_we = 1'b0;
  logic [3:0]         coef_addr = '0;
  logic signed [17:0] coef_data = '0;
  logic               coef_err;
  logic signed [17:0] mul_a, mul_b;
  logic signed [35:0] mul_p;
  logic signed [39:0] m_data;
  logic               m_valid;
  logic               m_ready = 1'b0;
  logic               busy;

  logic               t5_s_ready, t5_coef_err, t5_m_valid, t5_busy;
  logic               t5_coef_we = 1'b0;
  logic [2:0]         t5_coef_addr = '0;
  logic signed [17:0] t5_coef_data = '0;
  logic signed [17:0] t5_mul_a, t5_mul_b;
  logic signed [35:0] t5_mul_p;
  logic signed [39:0] t5_m_data;

  always #5 ap_clk = ~ap_clk;

  assign mul_p    = mul_a * mul_b;
  assign t5_mul_p = t5_mul_a * t5_mul_b;

  fir_filter_mac_sched #(.N_TAPS(16), .DATA_W(18), .ACC_W(40)) u_dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_err(coef_err),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .busy(busy)
  );

  fir_filter_mac_sched #(.N_TAPS(5), .DATA_W(18), .ACC_W(40)) u_dut5 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .s_data(18'sd0), .s_valid(1'b0), .s_ready(t5_s_ready),
    .coef_we(t5_coef_we), .coef_addr(t5_coef_addr), .coef_data(t5_coef_data), .coef_err(t5_coef_err),
    .mul_a(t5_mul_a), .mul_b(t5_mul_b), .mul_p(t5_mul_p),
    .m_data(t5_m_data), .m_valid(t5_m_valid), .m_ready(1'b1), .busy(t5_busy)
  );

  typedef struct {
    logic signed [17:0] samp;
    logic signed [39:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!s_ready && n < 100) begin
      @(negedge ap_clk);
      n++;
    end
    if (!s_ready) chk("s_ready_timeout", s_ready, 1);
  endtask

  task automatic wait_mvalid();
    int n = 0;
    while (!m_valid && n < 100) begin
      @(negedge ap_clk);
      n++;
    end
    if (!m_valid) chk("m_valid_timeout", m_valid, 1);
  endtask

  task automatic write_coef(input int addr, input logic signed [17:0] data);
    wait_ready();
    coef_we = 1'b1; coef_addr = 4'(addr); coef_data = data;
    @(negedge ap_clk);
    coef_we = 1'b0;
    chk($sformatf("coef_err_legal[%0d]", addr), coef_err, 0);
  endtask

  task automatic start_sample(input logic signed [17:0] x);
    wait_ready();
    s_data = x; s_valid = 1'b1;
    @(negedge ap_clk);
    s_valid = 1'b0;
  endtask

  task automatic finish(output logic signed [39:0] res);
    wait_mvalid();
    res = m_data;
    m_ready = 1'b1;
    @(negedge ap_clk);
    m_ready = 1'b0;
  endtask

  task automatic run_table(input string name);
    logic signed [39:0] r;
    for (int i = 0; i < tbl.size(); i++) begin
      start_sample(tbl[i].samp);
      finish(r);
      chk($sformatf("%s[%0d]", name, i), r, tbl[i].exp);
    end
  endtask

  initial begin
    logic signed [39:0] r;
    longint pn, pp;
    int acc_t[$];
    int mv_t[$];
    bit saw;

    // Reset state, including a sample offered while reset is held.
    s_valid = 1'b1;
    repeat (3) @(negedge ap_clk);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_coef_err", coef_err, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    s_valid = 1'b0;
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    chk("post_rst_idle", busy, 0);

    // Extremes: most negative coefficients and samples, then max positive samples.
    for (int k = 0; k < 16; k++) write_coef(k, -18'sd131072);
    pp = 64'sd17179869184;     // (-131072)*(-131072)
    pn = -64'sd17179738112;    // (-131072)*131071
    tbl.delete();
    for (int k = 1; k <= 16; k++) tbl.push_back('{samp: -18'sd131072, exp: 40'(k * pp)});
    for (int k = 1; k <= 16; k++) tbl.push_back('{samp: 18'sd131071, exp: 40'(k * pn + (16 - k) * pp)});
    run_table("extreme");
    chk("extreme_16th_const", tbl[15].exp, 64'sd274877906944);

    // Reset during MAC cycle 7 of a pass: no result, history cleared.
    start_sample(18'sd9);
    repeat (6) @(negedge ap_clk);
    chk("mid_mac_busy", busy, 1);
    ap_rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_m_valid", m_valid, 0);
    chk("abort_mul_a", mul_a, 0);
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    saw = 1'b0;
    repeat (30) begin
      @(negedge ap_clk);
      saw |= m_valid;
    end
    chk("abort_no_result", saw, 0);

    // Impulse response with coef[k] = k+1 on a cleared delay line.
    for (int k = 0; k < 16; k++) write_coef(k, 18'(k + 1));
    tbl.delete();
    tbl.push_back('{samp: 18'sd1, exp: 40'sd1});
    for (int k = 2; k <= 16; k++) tbl.push_back('{samp: 18'sd0, exp: 40'(k)});
    tbl.push_back('{samp: 18'sd0, exp: 40'sd0});
    run_table("impulse");

    // Sample and coefficient write on the same cycle: new coef[0]=7 used.
    wait_ready();
    s_data = 18'sd5; s_valid = 1'b1;
    coef_we = 1'b1; coef_addr = 4'd0; coef_data = 18'sd7;
    @(negedge ap_clk);
    s_valid = 1'b0; coef_we = 1'b0;
    chk("same_cycle_no_err", coef_err, 0);
    finish(r);
    chk("same_cycle_result", r, 35);

    // Write during MAC is dropped: x=[0,5,...], result coef[1]*5 = 10.
    start_sample(18'sd0);
    repeat (2) @(negedge ap_clk);
    coef_we = 1'b1; coef_addr = 4'd1; coef_data = 18'sd100;
    @(negedge ap_clk);
    coef_we = 1'b0;
    chk("mac_write_err_hi", coef_err, 1);
    @(negedge ap_clk);
    chk("mac_write_err_lo", coef_err, 0);
    finish(r);
    chk("mac_write_result", r, 10);

    // Backpressure: x=[0,0,5,...], result coef[2]*5 = 15, held 5 cycles.
    start_sample(18'sd0);
    wait_mvalid();
    for (int i = 0; i < 5; i++) begin
      @(negedge ap_clk);
      chk($sformatf("bp_m_data[%0d]", i), m_data, 15);
      chk($sformatf("bp_s_ready[%0d]", i), s_ready, 0);
      chk($sformatf("bp_busy[%0d]", i), busy, 1);
      chk($sformatf("bp_m_valid[%0d]", i), m_valid, 1);
    end
    m_ready = 1'b1;
    @(negedge ap_clk);
    m_ready = 1'b0;
    chk("bp_release_s_ready", s_ready, 1);
    chk("bp_release_m_valid", m_valid, 0);

    // Throughput and latency with both handshakes held high.
    wait_ready();
    s_data = 18'sd0; s_valid = 1'b1; m_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (s_ready) acc_t.push_back(c);
      if (m_valid) mv_t.push_back(c);
      @(negedge ap_clk);
    end
    s_valid = 1'b0;
    wait_ready();
    m_ready = 1'b0;
    chk("tp_accept_count", acc_t.size(), 4);
    chk("tp_valid_count", mv_t.size(), 3);
    if (acc_t.size() >= 4 && mv_t.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("tp_gap[%0d]", i), acc_t[i+1] - acc_t[i], 18);
        chk($sformatf("tp_latency[%0d]", i), mv_t[i] - acc_t[i], 17);
      end
    end

    // Out-of-range address on a 5-tap instance, then an in-range one.
    @(negedge ap_clk);
    t5_coef_we = 1'b1; t5_coef_addr = 3'd5; t5_coef_data = 18'sd3;
    @(negedge ap_clk);
    t5_coef_we = 1'b0;
    chk("range_err_hi", t5_coef_err, 1);
    @(negedge ap_clk);
    chk("range_err_lo", t5_coef_err, 0);
    t5_coef_we = 1'b1; t5_coef_addr = 3'd4;
    @(negedge ap_clk);
    t5_coef_we = 1'b0;
    chk("range_ok_no_err", t5_coef_err, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
